// File: rtl/jts16b_mcu_busarb.sv
// -----------------------------------------------------------------------------
// jts16b_mcu_busarb
//
// Lets the sound/protection MCU borrow the 68000 main bus. It keeps the MCU
// in reset until a number of vertical interrupts have passed. It turns each
// MCU external-memory strobe into one 68000 bus-request/grant/acknowledge
// handshake plus one access to the main-bus mapper. The MCU is stalled while
// the handshake runs.
//
// Ports
//   clk24, rst24       MCU-domain clock, asynchronous active-high reset
//   mcu_en_i           MCU fitted; low holds the MCU in reset and the FSM idle
//   vint_i             vertical interrupt level (asynchronous)
//   mcu_rst_o          MCU reset, active-high
//   mcu_acc_i          MCU external access strobe (level, clk24 domain)
//   mcu_wr_i           access is a write
//   mcu_addr_i/dout_i  MCU address / write data
//   mcu_din_o          read data returned to the MCU (8'hFF on read timeout)
//   mcu_stall_o        freezes the MCU clock enable
//   cpu_brn_o          68000 bus request (active-low)
//   cpu_bgn_i          68000 bus grant (active-low, asynchronous)
//   cpu_bgackn_o       68000 bus-grant acknowledge (active-low)
//   bus_req_o/we_o     access request / write qualifier to the mapper
//   bus_addr_o/dout_o  latched access address / write data
//   bus_ok_i           mapper access complete (asynchronous level)
//   bus_din_i          mapper read data, stable while bus_ok_i is high
//   tout_flag_o        sticky: some access was aborted by the timeout
//
// Parameters
//   TOUT   cycles allowed in REQ or ACCESS before the access is aborted (>= 1)
//   BOOTV  vint rising edges counted before the MCU leaves reset
// -----------------------------------------------------------------------------
module jts16b_mcu_busarb #(
  parameter int unsigned TOUT  = 255,
  parameter int unsigned BOOTV = 2
) (
  input  logic        clk24,
  input  logic        rst24,
  input  logic        mcu_en_i,
  input  logic        vint_i,
  output logic        mcu_rst_o,
  input  logic        mcu_acc_i,
  input  logic        mcu_wr_i,
  input  logic [15:0] mcu_addr_i,
  input  logic [7:0]  mcu_dout_i,
  output logic [7:0]  mcu_din_o,
  output logic        mcu_stall_o,
  output logic        cpu_brn_o,
  input  logic        cpu_bgn_i,
  output logic        cpu_bgackn_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [15:0] bus_addr_o,
  output logic [7:0]  bus_dout_o,
  input  logic        bus_ok_i,
  input  logic [7:0]  bus_din_i,
  output logic        tout_flag_o
);

  localparam int unsigned TW = $clog2(TOUT + 1);
  localparam int unsigned BW = $clog2(BOOTV + 2);

  // The TOUT-th cycle spent in REQ or ACCESS is the last one.
  localparam logic [TW-1:0] TOUT_LAST = TW'(TOUT - 1);
  localparam logic [TW-1:0] TOUT_MAX  = TW'(TOUT);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOTV);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_ACCESS,
    ST_DONE,
    ST_REL
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers. The grant resets to its inactive (high) level so that no
  // grant can be seen while reset is released.
  // ---------------------------------------------------------------------------
  logic [1:0] vint_sync_q, bgn_sync_q, ok_sync_q;
  logic       vint_s, bgn_s, ok_s;

  always_ff @(posedge clk24 or posedge rst24) begin
    if (rst24) begin
      vint_sync_q <= 2'b00;
      bgn_sync_q  <= 2'b11;
      ok_sync_q   <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value
      // of its neighbour, so the two stages really are two clock delays.
      vint_sync_q <= {vint_sync_q[0], vint_i};
      bgn_sync_q  <= {bgn_sync_q[0],  cpu_bgn_i};
      ok_sync_q   <= {ok_sync_q[0],   bus_ok_i};
    end
  end

  assign vint_s = vint_sync_q[1];
  assign bgn_s  = bgn_sync_q[1];
  assign ok_s   = ok_sync_q[1];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t          state_q,     state_d;
  logic            vint_prev_q;
  logic            acc_prev_q;
  logic [BW-1:0]   boot_cnt_q,  boot_cnt_d;
  logic            mcu_rst_q,   mcu_rst_d;
  logic [TW-1:0]   tout_cnt_q,  tout_cnt_d;
  logic [15:0]     bus_addr_q,  bus_addr_d;
  logic [7:0]      bus_dout_q,  bus_dout_d;
  logic            bus_we_q,    bus_we_d;
  logic [7:0]      mcu_din_q,   mcu_din_d;
  logic            tout_flag_q, tout_flag_d;

  logic vint_rise, acc_rise;
  logic start, data_hit, tout_hit, tout_expired;

  assign vint_rise    = vint_s & ~vint_prev_q;
  // The strobe already lives in clk24, so it is edge-detected directly.
  assign acc_rise     = mcu_acc_i & ~acc_prev_q;
  assign tout_expired = (tout_cnt_q >= TOUT_LAST);

  // ---------------------------------------------------------------------------
  // Boot counter: the MCU leaves reset one cycle after the count is reached.
  // ---------------------------------------------------------------------------
  always_comb begin
    boot_cnt_d = boot_cnt_q;
    if (!mcu_en_i) begin
      boot_cnt_d = '0;
    end else if (vint_rise && (boot_cnt_q < BOOT_LAST)) begin
      boot_cnt_d = boot_cnt_q + BW'(1);
    end
    mcu_rst_d = !mcu_en_i || (boot_cnt_q < BOOT_LAST);
  end

  // ---------------------------------------------------------------------------
  // Access FSM, next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    start    = 1'b0;
    data_hit = 1'b0;
    tout_hit = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (acc_rise && !mcu_rst_q) begin
          state_d = ST_REQ;
          start   = 1'b1;
        end
      end
      // A grant that arrives together with the timeout is still honoured.
      ST_REQ: begin
        if (!bgn_s) begin
          state_d = ST_GRANT;
        end else if (tout_expired) begin
          state_d  = ST_DONE;
          tout_hit = 1'b1;
        end
      end
      ST_GRANT: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (ok_s) begin
          state_d  = ST_DONE;
          data_hit = 1'b1;
        end else if (tout_expired) begin
          state_d  = ST_DONE;
          tout_hit = 1'b1;
        end
      end
      ST_DONE: state_d = ST_REL;
      // The strobe must drop before IDLE, so a held strobe is one access.
      ST_REL: begin
        if (!mcu_acc_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disabling the MCU wins over everything and abandons any access.
    if (!mcu_en_i) begin
      state_d  = ST_IDLE;
      start    = 1'b0;
      data_hit = 1'b0;
      tout_hit = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout counter: restarts on entry to REQ and to ACCESS, saturating.
  // ---------------------------------------------------------------------------
  always_comb begin
    tout_cnt_d = tout_cnt_q;
    if (!mcu_en_i) begin
      tout_cnt_d = '0;
    end else if ((state_d != state_q) &&
                 ((state_d == ST_REQ) || (state_d == ST_ACCESS))) begin
      tout_cnt_d = '0;
    end else if (((state_q == ST_REQ) || (state_q == ST_ACCESS)) &&
                 (tout_cnt_q != TOUT_MAX)) begin
      tout_cnt_d = tout_cnt_q + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_addr_d  = bus_addr_q;
    bus_dout_d  = bus_dout_q;
    bus_we_d    = bus_we_q;
    mcu_din_d   = mcu_din_q;
    tout_flag_d = tout_flag_q;

    if (start) begin
      bus_addr_d = mcu_addr_i;
      bus_dout_d = mcu_dout_i;
      bus_we_d   = mcu_wr_i;
    end

    // bus_din_i is stable by the time the synchronised ok is seen.
    if (data_hit && !bus_we_q) mcu_din_d = bus_din_i;

    if (tout_hit) begin
      tout_flag_d = 1'b1;
      if (!bus_we_q) mcu_din_d = 8'hFF;
    end

    if (!mcu_en_i) tout_flag_d = 1'b0;
  end

  always_ff @(posedge clk24 or posedge rst24) begin
    if (rst24) begin
      state_q     <= ST_IDLE;
      vint_prev_q <= 1'b0;
      acc_prev_q  <= 1'b0;
      boot_cnt_q  <= '0;
      mcu_rst_q   <= 1'b1;
      tout_cnt_q  <= '0;
      bus_addr_q  <= 16'h0000;
      bus_dout_q  <= 8'h00;
      bus_we_q    <= 1'b0;
      mcu_din_q   <= 8'hFF;
      tout_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vint_prev_q <= vint_s;
      acc_prev_q  <= mcu_acc_i;
      boot_cnt_q  <= boot_cnt_d;
      mcu_rst_q   <= mcu_rst_d;
      tout_cnt_q  <= tout_cnt_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
      bus_we_q    <= bus_we_d;
      mcu_din_q   <= mcu_din_d;
      tout_flag_q <= tout_flag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. These are decoded from the state register, so reset (which
  // forces IDLE) releases the bus asynchronously. The stall also covers the
  // strobe cycle itself, so the MCU never runs past an access it issued.
  // ---------------------------------------------------------------------------
  assign mcu_stall_o  = start || (state_q == ST_REQ) ||
                        (state_q == ST_GRANT) || (state_q == ST_ACCESS);
  assign cpu_brn_o    = (state_q != ST_REQ);
  assign cpu_bgackn_o = !((state_q == ST_GRANT) || (state_q == ST_ACCESS));
  assign bus_req_o    = (state_q == ST_ACCESS);
  assign bus_we_o     = bus_we_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_dout_o   = bus_dout_q;
  assign mcu_din_o    = mcu_din_q;
  assign mcu_rst_o    = mcu_rst_q;
  assign tout_flag_o  = tout_flag_q;

endmodule

// File: tb/tb_jts16b_mcu_busarb.sv
// -----------------------------------------------------------------------------
// tb_jts16b_mcu_busarb
//
// Bench for jts16b_mcu_busarb. It plays the MCU, the 68000 (grant after a
// random delay) and the main-bus mapper (a memory keyed by bus_addr). It
// predicts the MCU-visible read data from its own memory image of what the
// MCU has written. All inputs are driven and outputs sampled on the falling
// edge of clk24.
// -----------------------------------------------------------------------------
module tb_jts16b_mcu_busarb;

  localparam int TOUT  = 255;
  localparam int BOOTV = 2;

  logic        clk24 = 1'b0;
  logic        rst24;
  logic        mcu_en, vint, mcu_rst;
  logic        mcu_acc, mcu_wr;
  logic [15:0] mcu_addr;
  logic [7:0]  mcu_dout, mcu_din;
  logic        mcu_stall;
  logic        cpu_brn, cpu_bgn, cpu_bgackn;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout, bus_din;
  logic        bus_ok, tout_flag;

  always #5 clk24 = ~clk24;

  jts16b_mcu_busarb #(.TOUT(TOUT), .BOOTV(BOOTV)) dut (
    .clk24       (clk24),
    .rst24       (rst24),
    .mcu_en_i    (mcu_en),
    .vint_i      (vint),
    .mcu_rst_o   (mcu_rst),
    .mcu_acc_i   (mcu_acc),
    .mcu_wr_i    (mcu_wr),
    .mcu_addr_i  (mcu_addr),
    .mcu_dout_i  (mcu_dout),
    .mcu_din_o   (mcu_din),
    .mcu_stall_o (mcu_stall),
    .cpu_brn_o   (cpu_brn),
    .cpu_bgn_i   (cpu_bgn),
    .cpu_bgackn_o(cpu_bgackn),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_dout_o  (bus_dout),
    .bus_ok_i    (bus_ok),
    .bus_din_i   (bus_din),
    .tout_flag_o (tout_flag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: what the MCU wrote, and what it should last have read.
  // The mapper keeps its own image, filled only from what the DUT puts on
  // the bus, so a corrupted write shows up on a later read.
  // ---------------------------------------------------------------------------
  logic [7:0] ref_mem [logic [15:0]];
  logic [7:0] bus_mem [logic [15:0]];
  logic [7:0] exp_din = 8'hFF;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] bus_rd(input logic [15:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors: bus_req pulse count and handshake rule violations.
  // ---------------------------------------------------------------------------
  int   req_pulses = 0;
  int   viol       = 0;
  logic req_prev   = 1'b0;

  always @(negedge clk24) begin
    if (bus_req && !req_prev) req_pulses++;
    req_prev = bus_req;
    if (!cpu_brn && !cpu_bgackn) viol++;
    if (bus_req && cpu_bgackn)   viol++;
  end

  int stall_cyc;

  task automatic step();
    @(negedge clk24);
    if (mcu_stall) stall_cyc++;
  endtask

  // ---------------------------------------------------------------------------
  // Boot: BOOTV-1 pulses keep the MCU in reset, the last one releases it.
  // ---------------------------------------------------------------------------
  task automatic do_boot();
    int cyc;
    step();
    mcu_en = 1'b1;
    vint   = 1'b0;
    repeat (3) step();
    check("boot_rst_before_vint", mcu_rst, 1);
    for (int p = 1; p < BOOTV; p++) begin
      vint = 1'b1;
      repeat (4) step();
      vint = 1'b0;
      repeat (6) step();
    end
    check("boot_rst_short_count", mcu_rst, 1);
    vint = 1'b1;
    cyc  = 0;
    while (mcu_rst && cyc < 12) begin
      step();
      cyc++;
    end
    check("boot_released", mcu_rst, 0);
    // Two sync flops, one cycle to count, one cycle to release.
    check("boot_latency", (cyc >= 3 && cyc <= 5), 1);
    repeat (2) step();
    vint = 1'b0;
    repeat (4) step();
  endtask

  // ---------------------------------------------------------------------------
  // One complete MCU access with the 68000 and mapper responding.
  // ---------------------------------------------------------------------------
  task automatic do_access(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                           input int gdly, input int okdly, input int hold);
    int cyc;
    step();
    mcu_acc  = 1'b1;
    mcu_wr   = wr;
    mcu_addr = addr;
    mcu_dout = data;
    #1;
    check("acc_stall_same_cycle", mcu_stall, 1);
    stall_cyc = 1;

    cyc = 0;
    while (cpu_brn && cyc < 10) begin
      step();
      cyc++;
    end
    check("acc_brn_low", cpu_brn, 0);
    repeat (gdly) step();
    cpu_bgn = 1'b0;

    cyc = 0;
    while (!bus_req && cyc < 20) begin
      step();
      cyc++;
    end
    check("acc_bus_req", bus_req, 1);
    check("acc_bus_addr", bus_addr, addr);
    check("acc_bus_we", bus_we, wr);
    if (wr) check("acc_bus_dout", bus_dout, data);
    check("acc_brn_released", cpu_brn, 1);
    check("acc_bgackn_low", cpu_bgackn, 0);

    repeat (okdly) step();
    if (bus_we) bus_mem[bus_addr] = bus_dout;
    else        bus_din = bus_rd(bus_addr);
    bus_ok = 1'b1;

    cyc = 0;
    while (mcu_stall && cyc < 20) begin
      step();
      cyc++;
    end
    check("acc_stall_released", mcu_stall, 0);
    check("acc_done_bus_req", bus_req, 0);
    check("acc_done_bgackn", cpu_bgackn, 1);
    check("acc_done_brn", cpu_brn, 1);
    if (gdly == 0 && okdly == 0) check("acc_stall_le8", (stall_cyc <= 8), 1);
    bus_ok  = 1'b0;
    cpu_bgn = 1'b1;
    bus_din = 8'($urandom);

    if (wr) ref_mem[addr] = data;
    else    exp_din = ref_rd(addr);
    check("acc_mcu_din", mcu_din, exp_din);

    stall_cyc = 0;
    repeat (hold) step();
    check("acc_no_restall", stall_cyc, 0);
    mcu_acc = 1'b0;
    repeat (2) step();
  endtask

  // The 68000 never grants: the access must be abandoned after TOUT cycles.
  task automatic do_timeout(input logic wr, input logic [15:0] addr);
    int cyc;
    int snap;
    snap = req_pulses;
    step();
    mcu_acc  = 1'b1;
    mcu_wr   = wr;
    mcu_addr = addr;
    mcu_dout = 8'h77;
    #1;
    stall_cyc = 1;
    cyc = 0;
    while (mcu_stall && cyc < TOUT + 20) begin
      step();
      cyc++;
    end
    check("tout_stall_released", mcu_stall, 0);
    // Strobe cycle plus TOUT cycles in REQ.
    check("tout_length", (stall_cyc >= TOUT + 1 && stall_cyc <= TOUT + 2), 1);
    check("tout_flag_set", tout_flag, 1);
    check("tout_brn_high", cpu_brn, 1);
    check("tout_bgackn_high", cpu_bgackn, 1);
    check("tout_no_bus_req", req_pulses - snap, 0);
    if (!wr) exp_din = 8'hFF;
    check("tout_mcu_din", mcu_din, exp_din);
    mcu_acc = 1'b0;
    repeat (2) step();
  endtask

  // Runs an access up to ACCESS (bus_req high), leaving the grant asserted.
  task automatic start_to_access(input logic [15:0] addr);
    int cyc;
    step();
    mcu_acc  = 1'b1;
    mcu_wr   = 1'b0;
    mcu_addr = addr;
    cyc = 0;
    while (cpu_brn && cyc < 10) begin
      step();
      cyc++;
    end
    cpu_bgn = 1'b0;
    cyc = 0;
    while (!bus_req && cyc < 20) begin
      step();
      cyc++;
    end
    check("part_bus_req", bus_req, 1);
  endtask

  logic [15:0] pool [8];

  initial begin
    int snap;
    rst24    = 1'b1;
    mcu_en   = 1'b0;
    vint     = 1'b0;
    mcu_acc  = 1'b0;
    mcu_wr   = 1'b0;
    mcu_addr = 16'h0000;
    mcu_dout = 8'h00;
    cpu_bgn  = 1'b1;
    bus_ok   = 1'b0;
    bus_din  = 8'h00;
    stall_cyc = 0;

    #3;
    check("rst_mcu_rst", mcu_rst, 1);
    check("rst_stall", mcu_stall, 0);
    check("rst_brn", cpu_brn, 1);
    check("rst_bgackn", cpu_bgackn, 1);
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_we", bus_we, 0);
    check("rst_bus_addr", bus_addr, 16'h0000);
    check("rst_bus_dout", bus_dout, 8'h00);
    check("rst_mcu_din", mcu_din, 8'hFF);
    check("rst_tout_flag", tout_flag, 0);

    repeat (2) step();
    rst24 = 1'b0;
    repeat (2) step();

    // A strobe while the MCU is disabled and in reset is ignored.
    mcu_acc = 1'b1;
    #1;
    check("disabled_no_stall", mcu_stall, 0);
    repeat (4) step();
    check("disabled_no_brn", cpu_brn, 1);
    mcu_acc = 1'b0;
    step();

    do_boot();

    // Directed read and write.
    bus_mem[16'h1234] = 8'h5A;
    ref_mem[16'h1234] = 8'h5A;
    do_access(1'b0, 16'h1234, 8'h00, 3, 0, 0);
    check("read_1234_data", mcu_din, 8'h5A);
    do_access(1'b1, 16'h0800, 8'hC3, 0, 0, 0);
    check("write_keeps_din", mcu_din, 8'h5A);
    do_access(1'b0, 16'h0800, 8'h00, 0, 0, 0);
    check("read_back_0800", mcu_din, 8'hC3);

    // Random traffic over a small address pool so reads hit earlier writes.
    foreach (pool[i]) pool[i] = 16'($urandom);
    for (int n = 0; n < 40; n++) begin
      do_access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom),
                $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 3));
    end

    // Strobe held long after DONE: one access only.
    snap = req_pulses;
    do_access(1'b0, pool[0], 8'h00, 1, 1, 20);
    check("held_strobe_one_req", req_pulses - snap, 1);

    // Timeouts: a write leaves the read data alone, a read returns 8'hFF.
    exp_din = mcu_din;
    do_timeout(1'b1, 16'h0800);
    do_timeout(1'b0, 16'h1234);
    do_access(1'b0, 16'h0800, 8'h00, 2, 2, 0);
    check("tout_flag_sticky", tout_flag, 1);

    // Disabling the MCU during ACCESS.
    start_to_access(16'h0800);
    mcu_en = 1'b0;
    step();
    check("abort_bus_req", bus_req, 0);
    check("abort_bgackn", cpu_bgackn, 1);
    check("abort_brn", cpu_brn, 1);
    check("abort_mcu_rst", mcu_rst, 1);
    check("abort_stall", mcu_stall, 0);
    check("abort_tout_clear", tout_flag, 0);
    check("abort_din_kept", mcu_din, exp_din);
    cpu_bgn = 1'b1;
    mcu_acc = 1'b0;
    step();
    do_boot();

    // Reset in the middle of an access.
    start_to_access(pool[1]);
    #1 rst24 = 1'b1;
    #1;
    check("midrst_bus_req", bus_req, 0);
    check("midrst_bgackn", cpu_bgackn, 1);
    check("midrst_mcu_rst", mcu_rst, 1);
    check("midrst_mcu_din", mcu_din, 8'hFF);
    exp_din = 8'hFF;
    repeat (2) step();
    rst24   = 1'b0;
    cpu_bgn = 1'b1;
    snap    = req_pulses;
    repeat (20) step();
    check("midrst_no_more_req", req_pulses - snap, 0);
    check("midrst_still_in_reset", mcu_rst, 1);
    mcu_acc = 1'b0;
    step();
    do_boot();
    do_access(1'b0, 16'h1234, 8'h00, 0, 0, 0);

    check("handshake_rules", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
